// File: rtl/melody_player.sv
// melody_player: square-wave jingle sequencer (C5-E5-G5-C6); define MELODY_GAP_EN for a silent gap at the end of each slot
module melody_player #(
    parameter int NOTE_TICKS = 3125000,
    parameter int GAP_TICKS  = 250000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic       tone,
    output logic       busy,
    output logic       done,
    output logic [1:0] note_idx
);
`ifdef MELODY_GAP_EN
    typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;
    localparam logic [23:0] TONE_LAST = 24'(NOTE_TICKS - GAP_TICKS - 1);
`else
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
`endif
    localparam logic [23:0] SLOT_LAST = 24'(NOTE_TICKS - 1);
    localparam logic [15:0] ROM [4] = '{16'd23889, 16'd18961, 16'd15944, 16'd11944};

    state_t      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [23:0] slot_q, slot_d;
    logic [1:0]  note_q, note_d;
    logic        tone_q, tone_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        enable_q;
    logic [15:0] half;
    logic        adv;
    logic        last;

    assign half     = ROM[note_q];
    assign last     = note_q == 2'd3;
    assign tone     = tone_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign note_idx = note_q;

    // next state: tone generation, slot counting, note advance and stop
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        slot_d  = slot_q;
        note_d  = note_q;
        tone_d  = tone_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_q) begin
                    state_d = PLAY;
                    busy_d  = 1'b1;
                end
            end
            PLAY: begin
                phase_d = (half == 16'd0 || phase_q == half - 16'd1) ? 16'd0 : phase_q + 16'd1;
                tone_d  = (half == 16'd0) ? 1'b0 : (phase_q == half - 16'd1) ? ~tone_q : tone_q;
                slot_d  = slot_q + 24'd1;
`ifdef MELODY_GAP_EN
                if (slot_q == TONE_LAST) begin
                    state_d = GAP;
                    tone_d  = 1'b0;
                    phase_d = 16'd0;
                end
`else
                adv = slot_q == SLOT_LAST;
`endif
            end
`ifdef MELODY_GAP_EN
            GAP: begin
                slot_d = slot_q + 24'd1;
                adv    = slot_q == SLOT_LAST;
            end
`endif
            default: ;
        endcase
        // a slot end overrides any coincident phase toggle
        if (adv) begin
            tone_d  = 1'b0;
            phase_d = 16'd0;
            slot_d  = 24'd0;
            note_d  = last ? note_q : note_q + 2'd1;
            state_d = last ? DONE : PLAY;
            busy_d  = !last;
            done_d  = last;
        end
        // dropping enable always wins, even over the final slot end
        if (!enable_q && state_q != IDLE) begin
            state_d = IDLE;
            tone_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            phase_d = 16'd0;
            slot_d  = 24'd0;
            note_d  = 2'd0;
        end
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            phase_q  <= 16'd0;
            slot_q   <= 24'd0;
            note_q   <= 2'd0;
            tone_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            slot_q   <= slot_d;
            note_q   <= note_d;
            tone_q   <= tone_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            enable_q <= enable;
        end
    end
endmodule
